// File: rtl/avaliador_ativos_multi_if.sv
// Bus bundle between the neighbour-validation / expansion stages and the
// active-node evaluator.
interface avaliador_ativos_multi_if #(
    parameter int unsigned NUM_NA          = 8,
    parameter int unsigned ADDR_WIDTH      = 5,
    parameter int unsigned DISTANCIA_WIDTH = 5,
    parameter int unsigned CUSTO_WIDTH     = 4,
    parameter int unsigned NUM_WR          = 2
);
    localparam int unsigned CRITERIO_WIDTH = DISTANCIA_WIDTH + 1;

    logic                              fonte_valid_in;
    logic [ADDR_WIDTH-1:0]             fonte_endereco_in;
    logic [NUM_WR-1:0]                 ins_valid_in;
    logic [NUM_WR*ADDR_WIDTH-1:0]      ins_endereco_in;
    logic [NUM_WR*ADDR_WIDTH-1:0]      ins_anterior_in;
    logic [NUM_WR*DISTANCIA_WIDTH-1:0] ins_distancia_in;
    logic [NUM_WR*CUSTO_WIDTH-1:0]     ins_custo_in;
    logic                              ins_ready_out;
    logic                              classificar_in;
    logic                              desativar_in;
    logic [NUM_NA-1:0]                 aprovado_out;
    logic [NUM_NA*ADDR_WIDTH-1:0]      endereco_out;
    logic [NUM_NA*ADDR_WIDTH-1:0]      anterior_out;
    logic [NUM_NA*DISTANCIA_WIDTH-1:0] distancia_out;
    logic [CRITERIO_WIDTH-1:0]         criterio_min_out;
    logic                              tem_ativo_out;
    logic                              tem_aprovado_out;
    logic                              cheio_out;
    logic                              ocupado_out;
    logic                              pronto_out;
    logic                              overflow_out;

    modport master (
        output fonte_valid_in, fonte_endereco_in, ins_valid_in, ins_endereco_in,
               ins_anterior_in, ins_distancia_in, ins_custo_in, classificar_in, desativar_in,
        input  ins_ready_out, aprovado_out, endereco_out, anterior_out, distancia_out,
               criterio_min_out, tem_ativo_out, tem_aprovado_out, cheio_out, ocupado_out,
               pronto_out, overflow_out
    );

    modport slave (
        input  fonte_valid_in, fonte_endereco_in, ins_valid_in, ins_endereco_in,
               ins_anterior_in, ins_distancia_in, ins_custo_in, classificar_in, desativar_in,
        output ins_ready_out, aprovado_out, endereco_out, anterior_out, distancia_out,
               criterio_min_out, tem_ativo_out, tem_aprovado_out, cheio_out, ocupado_out,
               pronto_out, overflow_out
    );
endinterface

// File: rtl/avaliador_ativos_multi.sv
// Active-node evaluator: holds the open set of the path search, merges inserted
// candidates and approves the nodes with minimum distance + heuristic cost.
module avaliador_ativos_multi #(
    parameter int unsigned NUM_NA          = 8,
    parameter int unsigned ADDR_WIDTH      = 5,
    parameter int unsigned DISTANCIA_WIDTH = 5,
    parameter int unsigned CUSTO_WIDTH     = 4,
    parameter int unsigned NUM_WR          = 2,
    parameter int unsigned CMP_POR_CICLO   = 4
) (
    input logic                     clk,
    input logic                     rst_n,
    avaliador_ativos_multi_if.slave bus
);
    localparam int unsigned CRITERIO_WIDTH = DISTANCIA_WIDTH + 1;
    localparam int unsigned NUM_CICLOS     = (NUM_NA + CMP_POR_CICLO - 1) / CMP_POR_CICLO;
    localparam int unsigned CNT_MAX        = (NUM_WR > NUM_CICLOS) ? NUM_WR : NUM_CICLOS;
    localparam int unsigned CNT_WIDTH      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    typedef logic [ADDR_WIDTH-1:0]      addr_t;
    typedef logic [DISTANCIA_WIDTH-1:0] dist_t;
    typedef logic [CUSTO_WIDTH-1:0]     custo_t;
    typedef logic [CRITERIO_WIDTH-1:0]  crit_t;

    typedef enum logic [1:0] {StOcioso, StInserir, StClassificar, StAprovar} estado_e;

    estado_e                      r_estado, w_estado_d;
    logic [CNT_WIDTH-1:0]         r_cnt, w_cnt_d;
    logic [NUM_NA-1:0]            r_valid, w_valid_d;
    logic [NUM_NA-1:0]            r_aprovado, w_aprovado_d;
    addr_t                        r_endereco [NUM_NA];
    addr_t                        w_endereco_d [NUM_NA];
    addr_t                        r_anterior [NUM_NA];
    addr_t                        w_anterior_d [NUM_NA];
    dist_t                        r_distancia [NUM_NA];
    dist_t                        w_distancia_d [NUM_NA];
    custo_t                       r_custo [NUM_NA];
    custo_t                       w_custo_d [NUM_NA];
    crit_t                        r_min_run, w_min_run_d;
    crit_t                        r_criterio_min, w_criterio_min_d;
    logic                         r_pronto, w_pronto_d;
    logic                         r_overflow, w_overflow_d;

    logic [NUM_WR-1:0]                 r_ins_valid, w_ins_valid_d;
    logic [NUM_WR*ADDR_WIDTH-1:0]      r_ins_endereco, w_ins_endereco_d;
    logic [NUM_WR*ADDR_WIDTH-1:0]      r_ins_anterior, w_ins_anterior_d;
    logic [NUM_WR*DISTANCIA_WIDTH-1:0] r_ins_distancia, w_ins_distancia_d;
    logic [NUM_WR*CUSTO_WIDTH-1:0]     r_ins_custo, w_ins_custo_d;

    // Entry currently being applied by INSERIR (selected by r_cnt).
    logic   w_e_valid;
    addr_t  w_e_endereco;
    addr_t  w_e_anterior;
    dist_t  w_e_distancia;
    custo_t w_e_custo;

    logic [NUM_NA-1:0] w_match;
    logic [NUM_NA-1:0] w_livre;
    logic              w_achou_livre;
    crit_t             w_criterio [NUM_NA];
    crit_t             w_min_grupo;

    always_comb begin
        w_e_valid     = 1'b0;
        w_e_endereco  = '0;
        w_e_anterior  = '0;
        w_e_distancia = '0;
        w_e_custo     = '0;
        for (int k = 0; k < NUM_WR; k++) begin
            if (r_cnt == CNT_WIDTH'(k)) begin
                w_e_valid     = r_ins_valid[k];
                w_e_endereco  = r_ins_endereco[k*ADDR_WIDTH +: ADDR_WIDTH];
                w_e_anterior  = r_ins_anterior[k*ADDR_WIDTH +: ADDR_WIDTH];
                w_e_distancia = r_ins_distancia[k*DISTANCIA_WIDTH +: DISTANCIA_WIDTH];
                w_e_custo     = r_ins_custo[k*CUSTO_WIDTH +: CUSTO_WIDTH];
            end
        end
    end

    // Active addresses are kept unique, so at most one match bit is set.
    always_comb begin
        w_match       = '0;
        w_livre       = '0;
        w_achou_livre = 1'b0;
        for (int i = 0; i < NUM_NA; i++) begin
            if (r_valid[i] && (r_endereco[i] == w_e_endereco)) begin
                w_match[i] = 1'b1;
            end
            if (!r_valid[i] && !w_achou_livre) begin
                w_livre[i]    = 1'b1;
                w_achou_livre = 1'b1;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_NA; i++) begin
            w_criterio[i] = crit_t'(r_distancia[i]) + crit_t'(r_custo[i]);
        end
    end

    // Running minimum over the slot group scanned in this cycle.
    always_comb begin
        w_min_grupo = r_min_run;
        for (int i = 0; i < NUM_NA; i++) begin
            if (r_valid[i] && ((unsigned'(i) / CMP_POR_CICLO) == 32'(r_cnt))
                && (w_criterio[i] < w_min_grupo)) begin
                w_min_grupo = w_criterio[i];
            end
        end
    end

    always_comb begin
        w_estado_d        = r_estado;
        w_cnt_d           = r_cnt;
        w_valid_d         = r_valid;
        w_aprovado_d      = r_aprovado;
        w_endereco_d      = r_endereco;
        w_anterior_d      = r_anterior;
        w_distancia_d     = r_distancia;
        w_custo_d         = r_custo;
        w_min_run_d       = r_min_run;
        w_criterio_min_d  = r_criterio_min;
        w_pronto_d        = r_pronto;
        w_overflow_d      = r_overflow;
        w_ins_valid_d     = r_ins_valid;
        w_ins_endereco_d  = r_ins_endereco;
        w_ins_anterior_d  = r_ins_anterior;
        w_ins_distancia_d = r_ins_distancia;
        w_ins_custo_d     = r_ins_custo;

        if (bus.fonte_valid_in) begin
            w_valid_d        = '0;
            w_aprovado_d     = '0;
            w_valid_d[0]     = 1'b1;
            w_endereco_d[0]  = bus.fonte_endereco_in;
            w_anterior_d[0]  = bus.fonte_endereco_in;
            w_distancia_d[0] = '0;
            w_custo_d[0]     = '0;
            w_overflow_d     = 1'b0;
            w_pronto_d       = 1'b0;
            w_criterio_min_d = '1;
            w_cnt_d          = '0;
            w_estado_d       = StOcioso;
        end else begin
            case (r_estado)
                StOcioso: begin
                    if (bus.desativar_in) begin
                        w_valid_d    = r_valid & ~r_aprovado;
                        w_aprovado_d = '0;
                        w_pronto_d   = 1'b0;
                    end else if (|bus.ins_valid_in) begin
                        w_ins_valid_d     = bus.ins_valid_in;
                        w_ins_endereco_d  = bus.ins_endereco_in;
                        w_ins_anterior_d  = bus.ins_anterior_in;
                        w_ins_distancia_d = bus.ins_distancia_in;
                        w_ins_custo_d     = bus.ins_custo_in;
                        w_pronto_d        = 1'b0;
                        w_cnt_d           = '0;
                        w_estado_d        = StInserir;
                    end else if (bus.classificar_in) begin
                        w_min_run_d = '1;
                        w_cnt_d     = '0;
                        w_estado_d  = StClassificar;
                    end
                end
                StInserir: begin
                    if (w_e_valid) begin
                        if (|w_match) begin
                            for (int i = 0; i < NUM_NA; i++) begin
                                if (w_match[i] && (w_e_distancia < r_distancia[i])) begin
                                    w_distancia_d[i] = w_e_distancia;
                                    w_custo_d[i]     = w_e_custo;
                                    w_anterior_d[i]  = w_e_anterior;
                                    w_aprovado_d[i]  = 1'b0;
                                end
                            end
                        end else if (w_achou_livre) begin
                            for (int i = 0; i < NUM_NA; i++) begin
                                if (w_livre[i]) begin
                                    w_valid_d[i]     = 1'b1;
                                    w_aprovado_d[i]  = 1'b0;
                                    w_endereco_d[i]  = w_e_endereco;
                                    w_distancia_d[i] = w_e_distancia;
                                    w_custo_d[i]     = w_e_custo;
                                    w_anterior_d[i]  = w_e_anterior;
                                end
                            end
                        end else begin
                            w_overflow_d = 1'b1;
                        end
                    end
                    if (r_cnt == CNT_WIDTH'(NUM_WR - 1)) begin
                        w_cnt_d    = '0;
                        w_estado_d = StOcioso;
                    end else begin
                        w_cnt_d = r_cnt + 1'b1;
                    end
                end
                StClassificar: begin
                    w_min_run_d = w_min_grupo;
                    if (r_cnt == CNT_WIDTH'(NUM_CICLOS - 1)) begin
                        w_cnt_d    = '0;
                        w_estado_d = StAprovar;
                    end else begin
                        w_cnt_d = r_cnt + 1'b1;
                    end
                end
                StAprovar: begin
                    for (int i = 0; i < NUM_NA; i++) begin
                        w_aprovado_d[i] = r_valid[i] && (w_criterio[i] == r_min_run);
                    end
                    w_criterio_min_d = r_min_run;
                    w_pronto_d       = 1'b1;
                    w_estado_d       = StOcioso;
                end
                default: begin
                    w_estado_d = StOcioso;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_estado <= StOcioso;
        end else begin
            r_estado <= w_estado_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt           <= '0;
            r_valid         <= '0;
            r_aprovado      <= '0;
            r_endereco      <= '{default: '0};
            r_anterior      <= '{default: '0};
            r_distancia     <= '{default: '0};
            r_custo         <= '{default: '0};
            r_min_run       <= '1;
            r_criterio_min  <= '1;
            r_pronto        <= 1'b0;
            r_overflow      <= 1'b0;
            r_ins_valid     <= '0;
            r_ins_endereco  <= '0;
            r_ins_anterior  <= '0;
            r_ins_distancia <= '0;
            r_ins_custo     <= '0;
        end else begin
            r_cnt           <= w_cnt_d;
            r_valid         <= w_valid_d;
            r_aprovado      <= w_aprovado_d;
            r_endereco      <= w_endereco_d;
            r_anterior      <= w_anterior_d;
            r_distancia     <= w_distancia_d;
            r_custo         <= w_custo_d;
            r_min_run       <= w_min_run_d;
            r_criterio_min  <= w_criterio_min_d;
            r_pronto        <= w_pronto_d;
            r_overflow      <= w_overflow_d;
            r_ins_valid     <= w_ins_valid_d;
            r_ins_endereco  <= w_ins_endereco_d;
            r_ins_anterior  <= w_ins_anterior_d;
            r_ins_distancia <= w_ins_distancia_d;
            r_ins_custo     <= w_ins_custo_d;
        end
    end

    logic [NUM_NA*ADDR_WIDTH-1:0]      w_endereco_flat;
    logic [NUM_NA*ADDR_WIDTH-1:0]      w_anterior_flat;
    logic [NUM_NA*DISTANCIA_WIDTH-1:0] w_distancia_flat;

    always_comb begin
        w_endereco_flat  = '0;
        w_anterior_flat  = '0;
        w_distancia_flat = '0;
        for (int i = 0; i < NUM_NA; i++) begin
            w_endereco_flat[i*ADDR_WIDTH +: ADDR_WIDTH]           = r_endereco[i];
            w_anterior_flat[i*ADDR_WIDTH +: ADDR_WIDTH]           = r_anterior[i];
            w_distancia_flat[i*DISTANCIA_WIDTH +: DISTANCIA_WIDTH] = r_distancia[i];
        end
    end

    assign bus.aprovado_out     = r_aprovado;
    assign bus.endereco_out     = w_endereco_flat;
    assign bus.anterior_out     = w_anterior_flat;
    assign bus.distancia_out    = w_distancia_flat;
    assign bus.criterio_min_out = r_criterio_min;
    assign bus.tem_ativo_out    = |r_valid;
    assign bus.tem_aprovado_out = |r_aprovado;
    assign bus.cheio_out        = &r_valid;
    assign bus.ocupado_out      = (r_estado != StOcioso);
    assign bus.ins_ready_out    = (r_estado == StOcioso);
    assign bus.pronto_out       = r_pronto;
    assign bus.overflow_out     = r_overflow;

endmodule

// File: tb/tb_avaliador_ativos_multi.sv
// Bench for avaliador_ativos_multi: directed scenarios with literal expectations,
// then random traffic compared every cycle against a slot-list model.
module tb_avaliador_ativos_multi;
    localparam int unsigned NUM_NA = 8;
    localparam int unsigned AW     = 5;
    localparam int unsigned DW     = 5;
    localparam int unsigned CW     = 4;
    localparam int unsigned NUM_WR = 2;
    localparam int unsigned CMP    = 4;
    localparam int unsigned S      = (NUM_NA + CMP - 1) / CMP;
    localparam int          CMIN_MAX = (1 << (DW + 1)) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    avaliador_ativos_multi_if #(
        .NUM_NA(NUM_NA), .ADDR_WIDTH(AW), .DISTANCIA_WIDTH(DW), .CUSTO_WIDTH(CW), .NUM_WR(NUM_WR)
    ) bus ();

    avaliador_ativos_multi #(
        .NUM_NA(NUM_NA), .ADDR_WIDTH(AW), .DISTANCIA_WIDTH(DW), .CUSTO_WIDTH(CW),
        .NUM_WR(NUM_WR), .CMP_POR_CICLO(CMP)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: a plain list of slots plus a busy-cycle countdown.
    bit m_valid [NUM_NA];
    bit m_apr   [NUM_NA];
    int m_addr  [NUM_NA];
    int m_dist  [NUM_NA];
    int m_cost  [NUM_NA];
    int m_ant   [NUM_NA];
    bit m_ovf, m_pronto, m_on;
    int m_cmin, m_busy;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NUM_NA; i++) begin
            m_valid[i] = 0; m_apr[i] = 0;
            m_addr[i] = 0; m_dist[i] = 0; m_cost[i] = 0; m_ant[i] = 0;
        end
        m_ovf = 0; m_pronto = 0; m_cmin = CMIN_MAX; m_busy = 0;
    endtask

    task automatic model_insert(input int a, input int d, input int c, input int p);
        int hit;
        int fr;
        hit = -1; fr = -1;
        for (int i = 0; i < NUM_NA; i++) begin
            if (m_valid[i] && m_addr[i] == a) hit = i;
            if (!m_valid[i] && fr < 0) fr = i;
        end
        if (hit >= 0) begin
            if (d < m_dist[hit]) begin
                m_dist[hit] = d; m_cost[hit] = c; m_ant[hit] = p; m_apr[hit] = 0;
            end
        end else if (fr >= 0) begin
            m_valid[fr] = 1; m_apr[fr] = 0;
            m_addr[fr] = a; m_dist[fr] = d; m_cost[fr] = c; m_ant[fr] = p;
        end else begin
            m_ovf = 1;
        end
    endtask

    task automatic model_edge();
        bit idle;
        int mn;
        idle = (m_busy == 0);
        if (bus.fonte_valid_in) begin
            model_reset();
            m_valid[0] = 1;
            m_addr[0]  = int'(bus.fonte_endereco_in);
            m_ant[0]   = int'(bus.fonte_endereco_in);
        end else if (idle && bus.desativar_in) begin
            for (int i = 0; i < NUM_NA; i++) begin
                if (m_apr[i]) begin m_valid[i] = 0; m_apr[i] = 0; end
            end
            m_pronto = 0;
        end else if (idle && (|bus.ins_valid_in)) begin
            for (int k = 0; k < NUM_WR; k++) begin
                if (bus.ins_valid_in[k])
                    model_insert(int'(bus.ins_endereco_in[k*AW +: AW]),
                                 int'(bus.ins_distancia_in[k*DW +: DW]),
                                 int'(bus.ins_custo_in[k*CW +: CW]),
                                 int'(bus.ins_anterior_in[k*AW +: AW]));
            end
            m_pronto = 0;
            m_busy = NUM_WR;
        end else if (idle && bus.classificar_in) begin
            mn = CMIN_MAX;
            for (int i = 0; i < NUM_NA; i++)
                if (m_valid[i] && m_dist[i] + m_cost[i] < mn) mn = m_dist[i] + m_cost[i];
            for (int i = 0; i < NUM_NA; i++)
                m_apr[i] = m_valid[i] && (m_dist[i] + m_cost[i] == mn);
            m_cmin = mn; m_pronto = 1;
            m_busy = S + 1;
        end else if (!idle) begin
            m_busy--;
        end
    endtask

    task automatic clear_inputs();
        bus.fonte_valid_in    = 1'b0;
        bus.fonte_endereco_in = '0;
        bus.ins_valid_in      = '0;
        bus.ins_endereco_in   = '0;
        bus.ins_anterior_in   = '0;
        bus.ins_distancia_in  = '0;
        bus.ins_custo_in      = '0;
        bus.classificar_in    = 1'b0;
        bus.desativar_in      = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        model_edge();
        clear_inputs();
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 20 && m_busy != 0; n++) step();
    endtask

    task automatic fonte(input int a);
        bus.fonte_valid_in = 1'b1;
        bus.fonte_endereco_in = AW'(a);
        step();
    endtask

    task automatic ins_set(input logic [1:0] v, input int a0, input int d0, input int c0,
                           input int p0, input int a1, input int d1, input int c1, input int p1);
        bus.ins_valid_in     = v;
        bus.ins_endereco_in  = {AW'(a1), AW'(a0)};
        bus.ins_distancia_in = {DW'(d1), DW'(d0)};
        bus.ins_custo_in     = {CW'(c1), CW'(c0)};
        bus.ins_anterior_in  = {AW'(p1), AW'(p0)};
    endtask

    task automatic ins2(input logic [1:0] v, input int a0, input int d0, input int c0,
                        input int p0, input int a1, input int d1, input int c1, input int p1);
        ins_set(v, a0, d0, c0, p0, a1, d1, c1, p1);
        step();
        wait_idle();
    endtask

    task automatic classify();
        bus.classificar_in = 1'b1;
        step();
        wait_idle();
    endtask

    task automatic desativar();
        bus.desativar_in = 1'b1;
        step();
    endtask

    // Per-cycle comparison against the model whenever the DUT is idle.
    always @(negedge clk) begin
        if (m_on) begin
            logic [NUM_NA-1:0]    e_apr, e_val;
            logic [NUM_NA*AW-1:0] e_end, a_end, e_ant, a_ant;
            logic [NUM_NA*DW-1:0] e_dst, a_dst;
            chk("ocupado", 64'(bus.ocupado_out), 64'(m_busy != 0));
            chk("ins_ready", 64'(bus.ins_ready_out), 64'(m_busy == 0));
            if (m_busy == 0) begin
                e_apr = '0; e_val = '0; e_end = '0; a_end = '0;
                e_ant = '0; a_ant = '0; e_dst = '0; a_dst = '0;
                for (int i = 0; i < NUM_NA; i++) begin
                    e_apr[i] = m_apr[i];
                    e_val[i] = m_valid[i];
                    if (m_valid[i]) begin
                        e_end[i*AW +: AW] = AW'(m_addr[i]);
                        a_end[i*AW +: AW] = bus.endereco_out[i*AW +: AW];
                        e_ant[i*AW +: AW] = AW'(m_ant[i]);
                        a_ant[i*AW +: AW] = bus.anterior_out[i*AW +: AW];
                        e_dst[i*DW +: DW] = DW'(m_dist[i]);
                        a_dst[i*DW +: DW] = bus.distancia_out[i*DW +: DW];
                    end
                end
                chk("aprovado", 64'(bus.aprovado_out), 64'(e_apr));
                chk("endereco", 64'(a_end), 64'(e_end));
                chk("anterior", 64'(a_ant), 64'(e_ant));
                chk("distancia", 64'(a_dst), 64'(e_dst));
                chk("criterio_min", 64'(bus.criterio_min_out), 64'(m_cmin));
                chk("tem_ativo", 64'(bus.tem_ativo_out), 64'(|e_val));
                chk("tem_aprovado", 64'(bus.tem_aprovado_out), 64'(|e_apr));
                chk("cheio", 64'(bus.cheio_out), 64'(&e_val));
                chk("pronto", 64'(bus.pronto_out), 64'(m_pronto));
                chk("overflow", 64'(bus.overflow_out), 64'(m_ovf));
            end
        end
    end

    initial begin
        m_on = 0;
        model_reset();
        clear_inputs();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ins_ready", 64'(bus.ins_ready_out), 64'd1);
        chk("rst_ocupado", 64'(bus.ocupado_out), 64'd0);
        chk("rst_cmin", 64'(bus.criterio_min_out), 64'd63);
        chk("rst_aprovado", 64'(bus.aprovado_out), 64'd0);
        chk("rst_tem_ativo", 64'(bus.tem_ativo_out), 64'd0);
        chk("rst_pronto", 64'(bus.pronto_out), 64'd0);
        chk("rst_overflow", 64'(bus.overflow_out), 64'd0);
        chk("rst_endereco", 64'(bus.endereco_out), 64'd0);
        rst_n = 1'b1;
        m_on = 1;

        // Source node, then classification latency of S+1 edges.
        fonte(5);
        chk("src_addr", 64'(bus.endereco_out[AW-1:0]), 64'd5);
        chk("src_dist", 64'(bus.distancia_out[DW-1:0]), 64'd0);
        chk("src_tem_ativo", 64'(bus.tem_ativo_out), 64'd1);
        bus.classificar_in = 1'b1;
        step();
        step();
        step();
        chk("cls_pronto_early", 64'(bus.pronto_out), 64'd0);
        step();
        chk("cls_pronto", 64'(bus.pronto_out), 64'd1);
        chk("cls_aprovado_src", 64'(bus.aprovado_out), 64'h01);
        chk("cls_cmin_src", 64'(bus.criterio_min_out), 64'd0);
        desativar();

        // Two inserts; ins_ready low for NUM_WR cycles.
        ins_set(2'b11, 3, 4, 2, 5, 7, 2, 3, 5);
        step();
        chk("ins_ready_t0", 64'(bus.ins_ready_out), 64'd0);
        step();
        chk("ins_ready_t1", 64'(bus.ins_ready_out), 64'd0);
        wait_idle();
        chk("ins_ready_t2", 64'(bus.ins_ready_out), 64'd1);
        classify();
        chk("min5_aprovado", 64'(bus.aprovado_out), 64'h02);
        chk("min5_cmin", 64'(bus.criterio_min_out), 64'd5);
        desativar();
        chk("des_tem_aprovado", 64'(bus.tem_aprovado_out), 64'd0);
        chk("des_tem_ativo", 64'(bus.tem_ativo_out), 64'd1);

        // Duplicate merging on slot 0 (addr 3, dist 4, ant 5).
        ins2(2'b01, 3, 6, 0, 8, 0, 0, 0, 0);
        chk("dup_keep_dist", 64'(bus.distancia_out[DW-1:0]), 64'd4);
        chk("dup_keep_ant", 64'(bus.anterior_out[AW-1:0]), 64'd5);
        classify();
        chk("dup_apr_before", 64'(bus.aprovado_out), 64'h01);
        ins2(2'b01, 3, 1, 0, 9, 0, 0, 0, 0);
        chk("dup_new_dist", 64'(bus.distancia_out[DW-1:0]), 64'd1);
        chk("dup_new_ant", 64'(bus.anterior_out[AW-1:0]), 64'd9);
        chk("dup_apr_clr", 64'(bus.aprovado_out), 64'h00);

        // Tie: two nodes with criterion 4.
        fonte(0);
        ins2(2'b11, 1, 2, 2, 0, 2, 3, 1, 0);
        classify();
        desativar();
        classify();
        chk("tie_aprovado", 64'(bus.aprovado_out), 64'h06);
        chk("tie_cmin", 64'(bus.criterio_min_out), 64'd4);
        chk("tie_tem_aprovado", 64'(bus.tem_aprovado_out), 64'd1);

        // Fill all slots, then overflow.
        fonte(0);
        ins2(2'b11, 1, 1, 1, 0, 2, 2, 2, 0);
        ins2(2'b11, 3, 3, 3, 0, 4, 4, 4, 0);
        ins2(2'b11, 5, 5, 5, 0, 6, 6, 6, 0);
        ins2(2'b01, 7, 7, 7, 0, 0, 0, 0, 0);
        chk("fill_cheio", 64'(bus.cheio_out), 64'd1);
        chk("fill_no_ovf", 64'(bus.overflow_out), 64'd0);
        ins2(2'b01, 20, 1, 1, 0, 0, 0, 0, 0);
        chk("ovf_set", 64'(bus.overflow_out), 64'd1);
        fonte(1);
        chk("ovf_clr", 64'(bus.overflow_out), 64'd0);
        chk("ovf_cheio_clr", 64'(bus.cheio_out), 64'd0);

        // Abort classification with a new source.
        fonte(0);
        ins2(2'b01, 4, 3, 3, 0, 0, 0, 0, 0);
        classify();
        bus.classificar_in = 1'b1;
        step();
        fonte(9);
        chk("abort_ocupado", 64'(bus.ocupado_out), 64'd0);
        chk("abort_pronto", 64'(bus.pronto_out), 64'd0);
        chk("abort_addr", 64'(bus.endereco_out[AW-1:0]), 64'd9);
        chk("abort_cheio", 64'(bus.cheio_out), 64'd0);
        chk("abort_aprovado", 64'(bus.aprovado_out), 64'h00);

        // Random traffic; commands also land while busy and must be ignored.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 99) < 2) begin
                bus.fonte_valid_in = 1'b1;
                bus.fonte_endereco_in = AW'($urandom_range(0, 11));
            end else begin
                if ($urandom_range(0, 9) == 0) bus.desativar_in = 1'b1;
                if ($urandom_range(0, 2) == 0) begin
                    ins_set(2'($urandom_range(0, 3)),
                            $urandom_range(0, 11), $urandom_range(0, 31),
                            $urandom_range(0, 15), $urandom_range(0, 31),
                            $urandom_range(0, 11), $urandom_range(0, 31),
                            $urandom_range(0, 15), $urandom_range(0, 31));
                end
                if ($urandom_range(0, 3) == 0) bus.classificar_in = 1'b1;
            end
            step();
        end

        @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
